// File: rtl/interrupt_request_register_n.sv
// Parametrised interrupt request register: samples IR pins, applies
// per-channel level/edge triggering, holds pending requests until cleared,
// and retains edges seen while frozen so they post on release.
//
// Optional feature macro: IRR_INPUT_SYNC_EN
//   defined   -> pins pass through a SYNC_STAGES-deep synchroniser
//   undefined -> pins are used directly and must be synchronous to clock
//
// Ports:
//   clock, reset                   : rising-edge clock, async active-high reset
//   level_or_edge_triggered_config : per channel, 1 = level, 0 = edge
//   freeze                         : blocks all sets; clears still apply
//   clear_interrupt_request        : per-channel one-cycle clear pulse
//   interrupt_request_pin          : raw request pins
//   interrupt_request_register     : pending request vector
//   request_valid                  : any request pending
//   highest_request_index          : lowest-numbered pending bit, 0 if none

module interrupt_request_register_n #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int IDX_W       = $clog2(CHANNELS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] level_or_edge_triggered_config,
    input  logic                freeze,
    input  logic [CHANNELS-1:0] clear_interrupt_request,
    input  logic [CHANNELS-1:0] interrupt_request_pin,
    output logic [CHANNELS-1:0] interrupt_request_register,
    output logic                request_valid,
    output logic [IDX_W-1:0]    highest_request_index
);

    if (CHANNELS < 2 || CHANNELS > 32) begin : g_chk_channels
        $error("CHANNELS must be in 2..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_sync
        $error("SYNC_STAGES must be in 2..4");
    end

    logic [CHANNELS-1:0] s;

`ifdef IRR_INPUT_SYNC_EN
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_d [SYNC_STAGES];

    always_comb begin
        sync_d[0] = interrupt_request_pin;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];
`else
    assign s = interrupt_request_pin;
`endif

    logic [CHANNELS-1:0] prev_q, prev_d;
    logic [CHANNELS-1:0] held_q, held_d;
    logic [CHANNELS-1:0] irr_q, irr_d;
    logic [CHANNELS-1:0] edge_ev;

    // prev follows the sampled pin unconditionally, so mode switches
    // never manufacture an edge from a pin that is already high.
    assign prev_d  = s;
    assign edge_ev = s & ~prev_q;

    always_comb begin
        held_d = '0;
        irr_d  = irr_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (level_or_edge_triggered_config[i]) begin
                // Level mode drops any retained edge.
                held_d[i] = 1'b0;
                if (clear_interrupt_request[i]) begin
                    irr_d[i] = 1'b0;
                end else if (!freeze) begin
                    irr_d[i] = s[i];
                end
            end else if (freeze) begin
                held_d[i] = (held_q[i] & ~clear_interrupt_request[i])
                          | edge_ev[i];
                if (clear_interrupt_request[i]) begin
                    irr_d[i] = 1'b0;
                end
            end else begin
                // Released: retained and fresh edges merge into one set,
                // and a set beats a same-cycle clear.
                held_d[i] = 1'b0;
                if (edge_ev[i] | held_q[i]) begin
                    irr_d[i] = 1'b1;
                end else if (clear_interrupt_request[i]) begin
                    irr_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            held_q <= '0;
            irr_q  <= '0;
        end else begin
            prev_q <= prev_d;
            held_q <= held_d;
            irr_q  <= irr_d;
        end
    end

    logic [IDX_W-1:0] idx;

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (irr_q[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign interrupt_request_register = irr_q;
    assign request_valid              = |irr_q;
    assign highest_request_index      = idx;

endmodule

// File: tb/tb_interrupt_request_register_n.sv
// Bench for interrupt_request_register_n: vector table, directed corner
// sequences and randomized traffic against a behavioural model.

module tb_interrupt_request_register_n;

    localparam int SYNC = 2;
`ifdef IRR_INPUT_SYNC_EN
    localparam int NS = SYNC;
`else
    localparam int NS = 0;
`endif
    localparam int LAT = NS + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  cfg = '0;
    logic        frz = 1'b0;
    logic [7:0]  clr = '0;
    logic [7:0]  pin = '0;
    logic [7:0]  irr;
    logic        valid;
    logic [2:0]  idx;

    logic [15:0] cfg16 = '0;
    logic [15:0] clr16 = '0;
    logic [15:0] pin16 = '0;
    logic [15:0] irr16;
    logic        valid16;
    logic [3:0]  idx16;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    interrupt_request_register_n #(
        .CHANNELS(8), .SYNC_STAGES(SYNC)
    ) dut (
        .clock(clock), .reset(reset),
        .level_or_edge_triggered_config(cfg),
        .freeze(frz),
        .clear_interrupt_request(clr),
        .interrupt_request_pin(pin),
        .interrupt_request_register(irr),
        .request_valid(valid),
        .highest_request_index(idx)
    );

    interrupt_request_register_n #(
        .CHANNELS(16), .SYNC_STAGES(SYNC)
    ) dut16 (
        .clock(clock), .reset(reset),
        .level_or_edge_triggered_config(cfg16),
        .freeze(1'b0),
        .clear_interrupt_request(clr16),
        .interrupt_request_pin(pin16),
        .interrupt_request_register(irr16),
        .request_valid(valid16),
        .highest_request_index(idx16)
    );

    // Behavioural model: pin history queue gives the sampled value,
    // then per-channel pending rules are applied.
    logic [7:0] hq[$];
    logic [7:0] m_irr = '0;
    logic [7:0] m_held = '0;
    logic [7:0] m_prev = '0;

    task automatic model_reset();
        hq.delete();
        m_irr  = '0;
        m_held = '0;
        m_prev = '0;
    endtask

    task automatic model_edge();
        logic [7:0] s, e, n_irr, n_held;
        hq.push_back(pin);
        s = (hq.size() > NS) ? hq.pop_front() : 8'h00;
        e = s & ~m_prev;
        n_irr  = m_irr;
        n_held = '0;
        for (int i = 0; i < 8; i++) begin
            if (cfg[i]) begin
                if (clr[i]) n_irr[i] = 1'b0;
                else if (!frz) n_irr[i] = s[i];
            end else if (frz) begin
                if (clr[i]) n_irr[i] = 1'b0;
                n_held[i] = (m_held[i] && !clr[i]) || e[i];
            end else begin
                if (e[i] || m_held[i]) n_irr[i] = 1'b1;
                else if (clr[i]) n_irr[i] = 1'b0;
            end
        end
        m_irr  = n_irr;
        m_held = n_held;
        m_prev = s;
    endtask

    function automatic int low_idx(logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] cfg;
        logic       frz;
        logic [7:0] clr;
        logic [7:0] pin;
        logic [7:0] irr;
        logic [2:0] idx;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{8'hFF, 1'b0, 8'h00, 8'h04, 8'h04, 3'd2};
        tbl[1]  = '{8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0};
        tbl[2]  = '{8'h00, 1'b0, 8'h00, 8'h80, 8'h80, 3'd7};
        tbl[3]  = '{8'h00, 1'b0, 8'h80, 8'h80, 8'h00, 3'd0};
        tbl[4]  = '{8'h00, 1'b0, 8'h00, 8'h88, 8'h08, 3'd3};
        tbl[5]  = '{8'h00, 1'b0, 8'h08, 8'h00, 8'h00, 3'd0};
        tbl[6]  = '{8'h00, 1'b1, 8'h00, 8'h02, 8'h00, 3'd0};
        tbl[7]  = '{8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 3'd0};
        tbl[8]  = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h02, 3'd1};
        tbl[9]  = '{8'h02, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0};
        tbl[10] = '{8'hFF, 1'b0, 8'h00, 8'h0F, 8'h0F, 3'd0};
        tbl[11] = '{8'hF0, 1'b0, 8'h00, 8'h0F, 8'h0F, 3'd0};
        tbl[12] = '{8'hF0, 1'b0, 8'h0F, 8'h0F, 8'h00, 3'd0};
        tbl[13] = '{8'h00, 1'b1, 8'h00, 8'h0F, 8'h00, 3'd0};

        repeat (3) @(negedge clock);
        chk("reset_irr", 32'(irr), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_idx", 32'(idx), 32'h0);
        reset = 1'b0;
        model_reset();

        for (int v = 0; v < 14; v++) begin
            cfg = tbl[v].cfg;
            frz = tbl[v].frz;
            clr = tbl[v].clr;
            pin = tbl[v].pin;
            tick();
            clr = '0;
            repeat (LAT - 1) tick();
            chk($sformatf("vec%0d_irr", v), 32'(irr), 32'(tbl[v].irr));
            chk($sformatf("vec%0d_valid", v), 32'(valid),
                32'(tbl[v].irr != 0));
            chk($sformatf("vec%0d_idx", v), 32'(idx), 32'(tbl[v].idx));
        end

        // Level clear: drops for one edge, returns while pin is high.
        frz = 1'b0;
        cfg = 8'hFF;
        pin = 8'h04;
        repeat (LAT) tick();
        chk("lvl_set", 32'(irr), 32'h04);
        clr = 8'h04;
        tick();
        clr = '0;
        chk("lvl_clr", 32'(irr), 32'h00);
        tick();
        chk("lvl_reassert", 32'(irr), 32'h04);
        pin = 8'h00;
        repeat (LAT) tick();
        chk("lvl_drop", 32'(irr), 32'h00);

        // Edge wins over a same-cycle clear.
        cfg = 8'h00;
        pin = 8'h08;
        repeat (LAT) tick();
        chk("edge_set", 32'(irr), 32'h08);
        pin = 8'h00;
        repeat (LAT) tick();
        chk("edge_hold", 32'(irr), 32'h08);
        pin = 8'h08;
        repeat (LAT - 1) tick();
        clr = 8'h08;
        tick();
        clr = '0;
        chk("edge_beats_clr", 32'(irr), 32'h08);
        clr = 8'h08;
        tick();
        clr = '0;
        chk("edge_clr", 32'(irr), 32'h00);

        // Two pulses while frozen collapse into one request.
        pin = 8'h00;
        repeat (LAT) tick();
        frz = 1'b1;
        for (int k = 0; k < 2; k++) begin
            pin = 8'h02;
            repeat (LAT) tick();
            pin = 8'h00;
            repeat (LAT) tick();
        end
        chk("frz_blocked", 32'(irr), 32'h00);
        frz = 1'b0;
        tick();
        chk("frz_release", 32'(irr), 32'h02);
        clr = 8'h02;
        tick();
        clr = '0;
        tick();
        chk("frz_collapse", 32'(irr), 32'h00);

        // Held edge and a fresh edge on the release edge merge.
        frz = 1'b1;
        pin = 8'h02;
        repeat (LAT) tick();
        pin = 8'h00;
        repeat (LAT) tick();
        pin = 8'h02;
        repeat (LAT - 1) tick();
        frz = 1'b0;
        tick();
        chk("merge_set", 32'(irr), 32'h02);
        clr = 8'h02;
        tick();
        clr = '0;
        tick();
        chk("merge_single", 32'(irr), 32'h00);

        // Asynchronous reset mid-cycle, then edges seen from prev = 0.
        pin = 8'hFF;
        repeat (LAT) tick();
        chk("pre_reset", 32'(irr), 32'hFD);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_irr", 32'(irr), 32'h0);
        chk("async_rst_valid", 32'(valid), 32'h0);
        chk("async_rst_idx", 32'(idx), 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (LAT - 1) tick();
        chk("post_rst_early", 32'(irr), 32'h00);
        tick();
        chk("post_rst_set", 32'(irr), 32'hFF);

        // 16-channel priority summary.
        pin16 = 16'h8210;
        repeat (LAT) tick();
        chk("c16_irr", 32'(irr16), 32'h8210);
        chk("c16_idx4", 32'(idx16), 32'd4);
        chk("c16_valid", 32'(valid16), 32'd1);
        clr16 = 16'h0010;
        tick();
        clr16 = '0;
        chk("c16_idx9", 32'(idx16), 32'd9);
        clr16 = 16'h8200;
        tick();
        clr16 = '0;
        chk("c16_none_valid", 32'(valid16), 32'd0);
        chk("c16_none_idx", 32'(idx16), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) cfg = 8'($urandom);
            frz = ($urandom_range(0, 9) < 2);
            clr = 8'($urandom & $urandom & $urandom);
            pin = pin ^ 8'($urandom & $urandom);
            tick();
            chk("rnd_irr", 32'(irr), 32'(m_irr));
            chk("rnd_valid", 32'(valid), 32'(m_irr != 0));
            chk("rnd_idx", 32'(idx), 32'(low_idx(m_irr)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
